// File: rtl/led_mode_ctrl.sv
// Push-button LED mode controller: key sync/debounce, OFF/SLOW/FAST/ON mode FSM and blink prescaler.
// Optional auto-advance after AUTO_TOGGLES blink toggles is built when LED_MODE_AUTO_CYCLE_EN is defined.
module led_mode_ctrl #(
  parameter logic [24:0] CNT_SLOW_MAX = 25'd24_999_999,
  parameter logic [24:0] CNT_FAST_MAX = 25'd4_999_999,
  parameter logic [19:0] DEBOUNCE_MAX = 20'd999_999
`ifdef LED_MODE_AUTO_CYCLE_EN
  ,
  parameter logic [3:0]  AUTO_TOGGLES = 4'd8
`endif
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode_out,
  output logic       mode_chg
);

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_SLOW = 2'b01,
    S_FAST = 2'b10,
    S_ON   = 2'b11
  } mode_t;

  logic        r_sync1;
  logic        r_key_s;
  logic [19:0] r_deb_cnt;
  mode_t       r_mode;
  logic [24:0] r_cnt;
  logic        r_led;
  logic        r_chg;

  logic        w_press;
  logic        w_blink;
  logic [24:0] w_max;
  logic        w_tc;
  logic        w_auto;
  logic        w_adv;
  mode_t       w_next;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1   <= 1'b1;
      r_key_s   <= 1'b1;
      r_deb_cnt <= 20'd0;
    end else begin
      r_sync1 <= key_in;
      r_key_s <= r_sync1;
      if (r_key_s)
        r_deb_cnt <= 20'd0;
      else if (r_deb_cnt != DEBOUNCE_MAX)
        r_deb_cnt <= r_deb_cnt + 20'd1;
    end
  end

  // The counter saturates one past the press value, so a held key fires once.
  assign w_press = !r_key_s && (r_deb_cnt == DEBOUNCE_MAX - 20'd1);
  assign w_blink = (r_mode == S_SLOW) || (r_mode == S_FAST);
  assign w_max   = (r_mode == S_FAST) ? CNT_FAST_MAX : CNT_SLOW_MAX;
  assign w_tc    = w_blink && (r_cnt == w_max);
  assign w_next  = mode_t'(r_mode + 2'd1);

`ifdef LED_MODE_AUTO_CYCLE_EN
  logic [3:0] r_tog_cnt;

  // The toggle that would reach AUTO_TOGGLES is replaced by the mode advance.
  assign w_auto = w_tc && ((r_tog_cnt + 4'd1) == AUTO_TOGGLES);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_tog_cnt <= 4'd0;
    else if (w_adv)
      r_tog_cnt <= 4'd0;
    else if (w_tc)
      r_tog_cnt <= r_tog_cnt + 4'd1;
  end
`else
  assign w_auto = 1'b0;
`endif

  assign w_adv = w_press || w_auto;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode <= S_OFF;
      r_cnt  <= 25'd0;
      r_led  <= 1'b0;
      r_chg  <= 1'b0;
    end else begin
      r_chg <= w_adv;
      if (w_adv) begin
        // A mode change takes priority over a coincident terminal count.
        r_mode <= w_next;
        r_cnt  <= 25'd0;
        r_led  <= (w_next == S_ON);
      end else if (w_blink) begin
        if (w_tc) begin
          r_cnt <= 25'd0;
          r_led <= ~r_led;
        end else begin
          r_cnt <= r_cnt + 25'd1;
        end
      end else begin
        r_cnt <= 25'd0;
        r_led <= (r_mode == S_ON);
      end
    end
  end

  assign led_out  = r_led;
  assign mode_out = r_mode;
  assign mode_chg = r_chg;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: a timing-level reference model queues expected outputs per cycle,
// a monitor pops and compares on the falling edge; directed and random key stimulus.
module tb_led_mode_ctrl;

  localparam int DEB   = 4;
  localparam int SLOWM = 9;
  localparam int FASTM = 3;
  localparam int AUTO  = 3;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_in    = 1'b1;
  logic       led_out;
  logic [1:0] mode_out;
  logic       mode_chg;

  led_mode_ctrl #(
    .CNT_SLOW_MAX(25'd9),
    .CNT_FAST_MAX(25'd3),
    .DEBOUNCE_MAX(20'd4)
`ifdef LED_MODE_AUTO_CYCLE_EN
    ,
    .AUTO_TOGGLES(4'd3)
`endif
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_in   (key_in),
    .led_out  (led_out),
    .mode_out (mode_out),
    .mode_chg (mode_chg)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic       led;
    logic [1:0] mode;
    logic       chg;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a press lands two edges after the raw low run reaches DEB samples;
  // LED level is derived from the time elapsed since the last mode change.
  int m_run  = 0;
  int m_t    = 0;
  int m_mode = 0;
  bit m_chg  = 1'b0;
  bit m_h1   = 1'b0;
  bit m_h2   = 1'b0;

  function automatic int period(int md);
    return (md == 1) ? SLOWM + 1 : FASTM + 1;
  endfunction

  function automatic bit model_led(int md, int t);
    if (md == 3) return 1'b1;
    if (md == 0) return 1'b0;
    return bit'((t / period(md)) % 2);
  endfunction

  always @(posedge sys_clk) begin
    bit   press;
    bit   auto_adv;
    exp_t e;
    if (!sys_rst_n) begin
      m_run = 0; m_h1 = 0; m_h2 = 0;
      m_mode = 0; m_t = 0; m_chg = 0;
    end else begin
      m_run = key_in ? 0 : m_run + 1;
      press = m_h2;
      m_h2  = m_h1;
      m_h1  = (m_run == DEB);
      auto_adv = 1'b0;
`ifdef LED_MODE_AUTO_CYCLE_EN
      if ((m_mode == 1 || m_mode == 2) && (m_t + 1 == AUTO * period(m_mode)))
        auto_adv = 1'b1;
`endif
      if (press || auto_adv) begin
        m_mode = (m_mode + 1) % 4;
        m_t    = 0;
        m_chg  = 1'b1;
      end else begin
        m_t++;
        m_chg = 1'b0;
      end
    end
    e.led  = model_led(m_mode, m_t);
    e.mode = 2'(m_mode);
    e.chg  = m_chg;
    sb_q.push_back(e);
  end

  always @(negedge sys_clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({led_out, mode_out, mode_chg} !== e) begin
        errors++;
        $display("FAIL cycle_out t=%0t led/mode/chg actual=%b/%b/%b required=%b/%b/%b",
                 $time, led_out, mode_out, mode_chg, e.led, e.mode, e.chg);
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic press_key(input int low, input int high);
    key_in = 1'b0;
    cyc(low);
    key_in = 1'b1;
    cyc(high);
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  initial begin
    #500_000;
    errors++;
    $display("FAIL watchdog expired at t=%0t required=finish", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int tries;
    key_in    = 1'b1;
    sys_rst_n = 1'b0;
    cyc(3);
    check("rst_led", led_out, 0);
    check("rst_mode", mode_out, 0);
    check("rst_chg", mode_chg, 0);
    sys_rst_n = 1'b1;
    cyc(50);
    check("idle_mode", mode_out, 0);
    check("idle_led", led_out, 0);

    // Short glitches must not be accepted.
    press_key(2, 10);
    press_key(3, 10);
    check("glitch_no_press", mode_out, 0);

    // First press: latency and one-cycle change pulse.
    key_in = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sys_clk);
      if (mode_out == 2'b01) begin
        lat = i;
        break;
      end
    end
    check("press_latency", lat, 6);
    check("chg_pulse_hi", mode_chg, 1);
    check("slow_start_dark", led_out, 0);
    @(negedge sys_clk);
    check("chg_pulse_lo", mode_chg, 0);
    cyc(12);
    key_in = 1'b1;
    cyc(10);
    check("held_single_press", mode_out, 1);

    // Clean presses walk the mode ring.
    for (int k = 0; k < 7; k++) begin
      press_key(8, 12);
      check("seq_mode", mode_out, m_mode);
    end

    // Press landing on the SLOW terminal count.
    tries = 0;
    while (m_mode != 1 && tries < 6) begin
      press_key(8, 2);
      tries++;
    end
    check("reach_slow", mode_out, 1);
    tries = 0;
    while (!(m_mode == 1 && m_t == 14) && tries < 40) begin
      @(negedge sys_clk);
      tries++;
    end
    check("tc_align_found", int'(m_t == 14), 1);
    press_key(8, 2);
    check("tc_press_mode", mode_out, 2);
    cyc(20);

    // Asynchronous reset between edges with key held.
    key_in = 1'b0;
    cyc(3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_led", led_out, 0);
    check("async_rst_mode", mode_out, 0);
    check("async_rst_chg", mode_chg, 0);
    cyc(2);
    sys_rst_n = 1'b1;
    cyc(12);
    check("post_rst_press", mode_out, 1);
    key_in = 1'b1;
    cyc(10);

    // Long idle in SLOW: auto-advance build ends in ON, default build stays in SLOW.
    tries = 0;
    while (m_mode != 1 && tries < 6) begin
      press_key(8, 2);
      tries++;
    end
    cyc(200);
`ifdef LED_MODE_AUTO_CYCLE_EN
    check("auto_end_on", mode_out, 3);
    check("auto_on_led", led_out, 1);
`else
    check("no_auto_slow", mode_out, 1);
`endif

    // Randomized key activity.
    for (int r = 0; r < 80; r++)
      press_key(int'($urandom_range(1, 10)), int'($urandom_range(1, 40)));

    cyc(4);
    finish_run();
  end

endmodule
